// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, bit shifting on
// device clock falling edges, acknowledge check and timeout, open-drain enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t      state, state_n;
  logic        clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic        fe;
  logic [8:0]  frame, frame_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [31:0] cnt, cnt_n;
  logic        clk_oe_n, dat_oe_n, done_n, err_n;

  // Synchronizers reset high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fe = clk_d & ~clk_s2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      frame      <= '0;
      bit_cnt    <= '0;
      cnt        <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state      <= state_n;
      frame      <= frame_n;
      bit_cnt    <= bit_cnt_n;
      cnt        <= cnt_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      tx_done    <= done_n;
      tx_error   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bit_cnt_n = bit_cnt;
    cnt_n     = cnt;
    clk_oe_n  = ps2_clk_oe;
    dat_oe_n  = ps2_dat_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_n   = {~^tx_data, tx_data};
          bit_cnt_n = '0;
          cnt_n     = '0;
          clk_oe_n  = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 32'd1;
        if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_n    = '0;
          dat_oe_n = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        cnt_n = cnt + 32'd1;
        if (cnt == 32'(REQ_CYCLES - 1)) begin
          cnt_n    = '0;
          clk_oe_n = 1'b0;
          state_n  = SHIFT;
        end
      end
      SHIFT, ACK, WAIT_IDLE: begin
        cnt_n = cnt + 32'd1;
        if (state == SHIFT && fe) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd9) begin
            dat_oe_n = ~frame[0];
            frame_n  = frame >> 1;
          end else begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end
        end else if (state == ACK && fe) begin
          if (!dat_s2) begin
            state_n = WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (state == WAIT_IDLE && clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
        // Timeout takes priority over any protocol outcome in the same cycle.
        if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          done_n   = 1'b0;
          err_n    = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Not ready during a done/error pulse, so a waiting request lands one cycle later.
  assign tx_ready = (state == IDLE) && !tx_done && !tx_error;
  assign busy     = ~tx_ready;

endmodule
